// File: rtl/l2_fill_if.sv
// Fill request / line response bus between an L1 cache (master) and the next-level
// memory model (slave).
interface l2_fill_if;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic         resp_valid;
    logic [31:0]  resp_addr;
    logic [511:0] resp_data;
    logic         resp_ready;
    logic         busy;
    logic [15:0]  req_count;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_addr, resp_data, busy, req_count
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_addr, resp_data, busy, req_count
    );
endinterface

// File: rtl/l2_fill_stub.sv
// Next-level memory model: queues line-fill requests in order and returns one 512-bit
// line per request after a fixed latency. Line data is the byte address of each word.
module l2_fill_stub #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned QDEPTH  = 4
) (
    input logic      clk,
    input logic      rst,
    l2_fill_if.slave bus
);
    localparam int unsigned PtrW = $clog2(QDEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   occ_q, occ_d;
    logic [25:0]     cur_addr_q, cur_addr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [15:0]     req_count_q, req_count_d;
    logic [25:0]     mem_q [QDEPTH];

    logic full, empty, push, pop, resp_fire;
    logic unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[5:0];

    assign full      = (occ_q == (PtrW + 1)'(QDEPTH));
    assign empty     = (occ_q == '0);
    assign push      = bus.req_valid && bus.req_ready;
    assign pop       = (state_q == StIdle) && !empty;
    assign resp_fire = (state_q == StResp) && bus.resp_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        cur_addr_d  = cur_addr_q;
        cnt_d       = cnt_q;
        req_count_d = req_count_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    cur_addr_d = mem_q[rd_ptr_q];
                    cnt_d      = 8'(LATENCY - 1);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) state_d = StResp;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StResp: begin
                if (resp_fire) begin
                    if (req_count_q != 16'hFFFF) req_count_d = req_count_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            cur_addr_q  <= '0;
            cnt_q       <= '0;
            req_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            cur_addr_q  <= cur_addr_d;
            cnt_q       <= cnt_d;
            req_count_q <= req_count_d;
        end
    end

    // push is already gated by rst through req_ready
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.req_addr[31:6];
    end

    assign bus.req_ready  = !full && !rst;
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_addr  = bus.resp_valid ? {cur_addr_q, 6'b0} : '0;
    assign bus.busy       = (state_q != StIdle) || !empty;
    assign bus.req_count  = req_count_q;

    for (genvar k = 0; k < 16; k++) begin : g_word
        assign bus.resp_data[32*k +: 32] = bus.resp_valid ? {cur_addr_q, 4'(k), 2'b00} : '0;
    end
endmodule

// File: tb/tb_l2_fill_stub.sv
// Scoreboard bench for l2_fill_stub: expected line addresses are queued on each accepted
// request and compared against the responses captured on each handshake.
module tb_l2_fill_stub;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   exp_count;

    logic [31:0]  exp_q[$];
    logic [31:0]  obs_addr_q[$];
    logic [511:0] obs_data_q[$];

    l2_fill_if bus ();

    l2_fill_stub #(.LATENCY(4), .QDEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            obs_addr_q.push_back(bus.resp_addr);
            obs_data_q.push_back(bus.resp_data);
        end
    end

    function automatic logic [511:0] line_of(input logic [31:0] a);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = {a[31:6], 4'(k), 2'b00};
        return l;
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        obs_addr_q.delete();
        obs_data_q.delete();
    endtask

    task automatic wait_idle(output bit done);
        done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1; bus.req_valid = 0; bus.req_addr = '0; bus.resp_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0) begin failures++;
            $display("FAIL reset_resp_valid got %0b want 0", bus.resp_valid); end
        checks++; if (bus.resp_addr !== 32'h0) begin failures++;
            $display("FAIL reset_resp_addr got %h want 0", bus.resp_addr); end
        checks++; if (bus.resp_data !== 512'h0) begin failures++;
            $display("FAIL reset_resp_data got nonzero want 0"); end
        checks++; if (bus.req_count !== 16'h0) begin failures++;
            $display("FAIL reset_req_count got %0d want 0", bus.req_count); end
        checks++; if (bus.busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++;
            $display("FAIL reset_req_ready got %0b want 0", bus.req_ready); end
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++;
            $display("FAIL post_reset_req_ready got %0b want 1", bus.req_ready); end
        exp_count = 0;
    endtask

    task automatic test_latency();
        int n = 1;
        bit found = 0;
        clear_sb();
        @(posedge clk); #1;
        bus.resp_ready = 1; bus.req_valid = 1; bus.req_addr = 32'h00040A47;
        exp_q.push_back(32'h00040A40);
        @(posedge clk); #1; bus.req_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin found = 1; break; end
            @(posedge clk); #1; n++;
        end
        checks++; if (!found || n != 6) begin failures++;
            $display("FAIL latency got cycle %0d (found=%0b) want 6", n, found); end
        checks++; if (bus.resp_addr !== 32'h00040A40) begin failures++;
            $display("FAIL lat_addr got %h want 00040a40", bus.resp_addr); end
        checks++; if (bus.resp_data[31:0] !== 32'h00040A40) begin failures++;
            $display("FAIL lat_word0 got %h want 00040a40", bus.resp_data[31:0]); end
        checks++; if (bus.resp_data[511:480] !== 32'h00040A7C) begin failures++;
            $display("FAIL lat_word15 got %h want 00040a7c", bus.resp_data[511:480]); end
        @(posedge clk); #1; bus.resp_ready = 0;
        exp_count++;
        @(negedge clk);
        checks++; if (bus.req_count !== 16'(exp_count)) begin failures++;
            $display("FAIL lat_count got %0d want %0d", bus.req_count, exp_count); end
        checks++; if (bus.busy !== 1'b0) begin failures++;
            $display("FAIL lat_busy got %0b want 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        bit found = 0;
        logic [31:0] a = 32'h00ABCDC0;
        clear_sb();
        @(posedge clk); #1;
        bus.resp_ready = 0; bus.req_valid = 1; bus.req_addr = a;
        @(posedge clk); #1; bus.req_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin found = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!found) begin failures++;
            $display("FAIL bp_timeout got no resp_valid want resp_valid"); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_addr !== a ||
                          bus.resp_data !== line_of(a)) begin failures++;
                $display("FAIL bp_hold cycle %0d got valid=%0b addr=%h want valid=1 addr=%h",
                         c, bus.resp_valid, bus.resp_addr, a); end
        end
        @(posedge clk); #1; bus.resp_ready = 1;
        @(posedge clk); #1; bus.resp_ready = 0;
        exp_count++;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0) begin failures++;
            $display("FAIL bp_release got valid=%0b want 0", bus.resp_valid); end
        checks++; if (bus.req_count !== 16'(exp_count) || obs_addr_q.size() != 1) begin
            failures++;
            $display("FAIL bp_single_handshake got count=%0d hs=%0d want count=%0d hs=1",
                     bus.req_count, obs_addr_q.size(), exp_count); end
    endtask

    task automatic test_back_to_back();
        bit done;
        bit accepted = 0;
        clear_sb();
        @(posedge clk); #1;
        bus.resp_ready = 0;
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = 1; bus.req_addr = 32'(i * 64);
            @(negedge clk);
            checks++; if (bus.req_ready !== (i < 5)) begin failures++;
                $display("FAIL b2b_ready req %0d got %0b want %0b", i, bus.req_ready, i < 5); end
            if (bus.req_ready) exp_q.push_back(32'(i * 64));
            if (i < 5) begin @(posedge clk); #1; end
        end
        bus.resp_ready = 1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin accepted = 1; exp_q.push_back(32'h140); end
            @(posedge clk); #1;
        end
        bus.req_valid = 0;
        checks++; if (!accepted) begin failures++;
            $display("FAIL b2b_sixth got not accepted want accepted"); end
        wait_idle(done);
        checks++; if (!done) begin failures++;
            $display("FAIL b2b_idle_timeout got busy want idle"); end
        checks++; if (obs_addr_q.size() != exp_q.size()) begin failures++;
            $display("FAIL b2b_count got %0d want %0d", obs_addr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_addr_q.size(); i++) begin
            checks++; if (obs_addr_q[i] !== exp_q[i] || obs_data_q[i] !== line_of(exp_q[i]))
            begin failures++;
                $display("FAIL b2b_order idx %0d got %h want %h", i, obs_addr_q[i], exp_q[i]);
            end
        end
        exp_count += exp_q.size();
        checks++; if (bus.req_count !== 16'(exp_count)) begin failures++;
            $display("FAIL b2b_req_count got %0d want %0d", bus.req_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        @(posedge clk); #1;
        bus.resp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1; bus.req_addr = 32'h1000 + 32'(i * 64);
            @(posedge clk); #1;
        end
        rst = 1; bus.req_addr = 32'h2000;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin failures++;
            $display("FAIL rst_mid_ready got %0b want 0", bus.req_ready); end
        @(posedge clk); #1; rst = 0; bus.req_valid = 0;
        exp_count = 0;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 ||
                      bus.req_count !== 16'h0) begin failures++;
            $display("FAIL rst_mid_state got valid=%0b busy=%0b count=%0d want 0 0 0",
                     bus.resp_valid, bus.busy, bus.req_count); end
        bus.resp_ready = 1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        checks++; if (obs_addr_q.size() != 0 || bus.busy !== 1'b0) begin failures++;
            $display("FAIL rst_mid_flush got %0d responses busy=%0b want 0 0",
                     obs_addr_q.size(), bus.busy); end
    endtask

    task automatic test_full_ignore();
        bit done;
        clear_sb();
        @(posedge clk); #1;
        bus.resp_ready = 0; bus.req_valid = 1;
        for (int i = 0; i < 8; i++) begin
            bus.req_addr = 32'h3000 + 32'(i * 64);
            @(negedge clk);
            checks++; if (bus.req_ready !== (i < 5)) begin failures++;
                $display("FAIL full_ready req %0d got %0b want %0b", i, bus.req_ready, i < 5); end
            if (bus.req_ready) exp_q.push_back(bus.req_addr);
            @(posedge clk); #1;
        end
        bus.req_valid = 0; bus.resp_ready = 1;
        wait_idle(done);
        checks++; if (!done || obs_addr_q.size() != exp_q.size()) begin failures++;
            $display("FAIL full_count got %0d (idle=%0b) want %0d",
                     obs_addr_q.size(), done, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_addr_q.size(); i++) begin
            checks++; if (obs_addr_q[i] !== exp_q[i] || obs_data_q[i] !== line_of(exp_q[i]))
            begin failures++;
                $display("FAIL full_order idx %0d got %h want %h", i, obs_addr_q[i], exp_q[i]);
            end
        end
        exp_count += exp_q.size();
        checks++; if (bus.req_count !== 16'(exp_count)) begin failures++;
            $display("FAIL full_req_count got %0d want %0d", bus.req_count, exp_count); end
    endtask

    task automatic test_push_pop();
        bit done;
        bit found = 0;
        clear_sb();
        @(posedge clk); #1;
        bus.resp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1; bus.req_addr = 32'h4000 + 32'(i * 64);
            exp_q.push_back(bus.req_addr);
            @(posedge clk); #1;
        end
        bus.req_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin found = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!found) begin failures++;
            $display("FAIL pp_timeout got no resp_valid want resp_valid"); end
        @(posedge clk); #1; bus.resp_ready = 1;
        @(posedge clk); #1; bus.resp_ready = 0;
        bus.req_valid = 1; bus.req_addr = 32'h40C0;
        exp_q.push_back(32'h40C0);
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++;
            $display("FAIL pp_idle got valid=%0b ready=%0b want 0 1",
                     bus.resp_valid, bus.req_ready); end
        @(posedge clk); #1; bus.req_valid = 0; bus.resp_ready = 1;
        wait_idle(done);
        checks++; if (!done || obs_addr_q.size() != exp_q.size()) begin failures++;
            $display("FAIL pp_count got %0d (idle=%0b) want %0d",
                     obs_addr_q.size(), done, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_addr_q.size(); i++) begin
            checks++; if (obs_addr_q[i] !== exp_q[i] || obs_data_q[i] !== line_of(exp_q[i]))
            begin failures++;
                $display("FAIL pp_order idx %0d got %h want %h", i, obs_addr_q[i], exp_q[i]);
            end
        end
        exp_count += exp_q.size();
        checks++; if (bus.req_count !== 16'(exp_count)) begin failures++;
            $display("FAIL pp_req_count got %0d want %0d", bus.req_count, exp_count); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_full_ignore();
        test_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
